// File: rtl/rotmat_to_quat.sv
`default_nettype none
// ============================================================================
// rotmat_to_quat: 3x3 rotation matrix (Q1.30) to unit quaternion (Q1.30),
// Shepperd's method, one restoring sqrt then three restoring divides.
// Revision: 1.0
// ============================================================================
module rotmat_to_quat #(
  parameter int W    = 32,
  parameter int ITER = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] r00,
  input  logic signed [W-1:0] r01,
  input  logic signed [W-1:0] r02,
  input  logic signed [W-1:0] r10,
  input  logic signed [W-1:0] r11,
  input  logic signed [W-1:0] r12,
  input  logic signed [W-1:0] r20,
  input  logic signed [W-1:0] r21,
  input  logic signed [W-1:0] r22,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] qw,
  output logic signed [W-1:0] qx,
  output logic signed [W-1:0] qy,
  output logic signed [W-1:0] qz
);

  localparam int CW = $clog2(ITER + 1);
  localparam int FB = W - 2;
  localparam logic signed [W+2:0] ONE = (W+3)'(1) <<< FB;
  localparam logic [W-1:0] LIM = W'(1) << FB;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [2:0] {IDLE, SEL, SQRT, DIV, FIN, OUT} state_t;

  state_t                state;
  logic   [CW-1:0]       cnt;
  logic   [1:0]          k;
  logic   [1:0]          sel;
  logic signed [W-1:0]   m00, m01, m02, m10, m11, m12, m20, m21, m22;
  logic signed [W:0]     n0, n1, n2;
  logic signed [W-1:0]   qres [3];
  logic   [2*W-1:0]      rad;
  logic   [W+1:0]        srem;
  logic   [W-1:0]        root;
  logic   [W-1:0]        drem;
  logic   [W-1:0]        dlo;

  assign in_ready = (state == IDLE) && !rst;

  // Diagonal sums in Q3.30 and the branch-dependent numerators.
  logic signed [W+2:0] e00, e11, e22, dw, dx, dy, dz, dsel;
  logic [1:0]          sel_c;
  logic signed [W:0]   a01, a02, a10, a12, a20, a21;
  logic signed [W:0]   nc0, nc1, nc2;

  always_comb begin
    e00 = (W+3)'(m00);
    e11 = (W+3)'(m11);
    e22 = (W+3)'(m22);
    dw  = ONE + e00 + e11 + e22;
    dx  = ONE + e00 - e11 - e22;
    dy  = ONE - e00 + e11 - e22;
    dz  = ONE - e00 - e11 + e22;
    sel_c = 2'd0;
    dsel  = dw;
    if (dx > dsel) begin sel_c = 2'd1; dsel = dx; end
    if (dy > dsel) begin sel_c = 2'd2; dsel = dy; end
    if (dz > dsel) begin sel_c = 2'd3; dsel = dz; end
    a01 = (W+1)'(m01);
    a02 = (W+1)'(m02);
    a10 = (W+1)'(m10);
    a12 = (W+1)'(m12);
    a20 = (W+1)'(m20);
    a21 = (W+1)'(m21);
    case (sel_c)
      2'd0:    begin nc0 = a21 - a12; nc1 = a02 - a20; nc2 = a10 - a01; end
      2'd1:    begin nc0 = a21 - a12; nc1 = a01 + a10; nc2 = a02 + a20; end
      2'd2:    begin nc0 = a02 - a20; nc1 = a01 + a10; nc2 = a12 + a21; end
      default: begin nc0 = a10 - a01; nc1 = a02 + a20; nc2 = a12 + a21; end
    endcase
  end

  // One restoring square-root step: two radicand bits in, one root bit out.
  logic [W+3:0] sq_rn, sq_trial;
  logic         sq_ge;
  logic [W+1:0] srem_nx;
  logic [W-1:0] root_nx;

  always_comb begin
    sq_rn    = {srem, rad[2*W-1 -: 2]};
    sq_trial = {2'b00, root, 2'b01};
    sq_ge    = (sq_rn >= sq_trial);
    srem_nx  = sq_ge ? (W+2)'(sq_rn - sq_trial) : (W+2)'(sq_rn);
    root_nx  = {root[W-2:0], sq_ge};
  end

  // One restoring divide step against h, plus the next dividend to load.
  logic [W:0]          dv_sh;
  logic                dv_ge;
  logic [W-1:0]        drem_nx, dlo_nx, qmag;
  logic signed [W-1:0] qsig;
  logic signed [W:0]   nsrc;
  logic [W:0]          nabs;
  logic [2*W-1:0]      dvd;

  always_comb begin
    dv_sh   = {drem, dlo[W-1]};
    dv_ge   = (dv_sh >= {1'b0, root});
    drem_nx = dv_ge ? W'(dv_sh - {1'b0, root}) : W'(dv_sh);
    dlo_nx  = {dlo[W-2:0], dv_ge};
    qmag    = (dlo_nx > LIM) ? LIM : dlo_nx;
    qsig    = n0[W] ? -$signed(qmag) : $signed(qmag);
    nsrc    = (state == SQRT) ? n0 : n1;
    nabs    = nsrc[W] ? (W+1)'(-nsrc) : (W+1)'(nsrc);
    dvd     = {{(W-1){1'b0}}, nabs} << (W-3);
  end

  // Place the half-root and the three quotients, then canonicalise qw >= 0.
  logic signed [W-1:0] hh, cw, cx, cy, cz;

  always_comb begin
    hh = $signed({1'b0, root[W-1:1]});
    case (sel)
      2'd0:    begin cw = hh;      cx = qres[0]; cy = qres[1]; cz = qres[2]; end
      2'd1:    begin cw = qres[0]; cx = hh;      cy = qres[1]; cz = qres[2]; end
      2'd2:    begin cw = qres[0]; cx = qres[1]; cy = hh;      cz = qres[2]; end
      default: begin cw = qres[0]; cx = qres[1]; cy = qres[2]; cz = hh;      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      qw        <= '0;
      qx        <= '0;
      qy        <= '0;
      qz        <= '0;
      cnt       <= '0;
      k         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            m00 <= r00; m01 <= r01; m02 <= r02;
            m10 <= r10; m11 <= r11; m12 <= r12;
            m20 <= r20; m21 <= r21; m22 <= r22;
            state <= SEL;
          end
        end
        SEL: begin
          sel   <= sel_c;
          n0    <= nc0;
          n1    <= nc1;
          n2    <= nc2;
          rad   <= {{(W-3){1'b0}}, dsel} << FB;
          srem  <= '0;
          root  <= '0;
          cnt   <= '0;
          state <= SQRT;
        end
        SQRT: begin
          rad  <= rad << 2;
          srem <= srem_nx;
          root <= root_nx;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            cnt   <= '0;
            k     <= '0;
            drem  <= dvd[2*W-1:W];
            dlo   <= dvd[W-1:0];
            state <= DIV;
          end
        end
        DIV: begin
          drem <= drem_nx;
          dlo  <= dlo_nx;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            qres[k] <= qsig;
            n0      <= n1;
            n1      <= n2;
            drem    <= dvd[2*W-1:W];
            dlo     <= dvd[W-1:0];
            cnt     <= '0;
            k       <= k + 1'b1;
            if (k == 2'd2) state <= FIN;
          end
        end
        FIN: begin
          qw        <= cw[W-1] ? -cw : cw;
          qx        <= cw[W-1] ? -cx : cx;
          qy        <= cw[W-1] ? -cy : cy;
          qz        <= cw[W-1] ? -cz : cz;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rotmat_to_quat.sv
`default_nettype none
// ============================================================================
// tb_rotmat_to_quat: directed-vector bench for rotmat_to_quat.
// Revision: 1.0
// ============================================================================
module tb_rotmat_to_quat;
  localparam int W = 32;
  localparam int ITER = 32;
  localparam logic signed [W-1:0] P1 = 32'sh40000000;
  localparam logic signed [W-1:0] N1 = -32'sh40000000;
  localparam logic signed [W-1:0] C150 = -32'sd929887697;
  localparam logic signed [W-1:0] S150 = 32'sd536870912;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid;
  logic signed [W-1:0] r00, r01, r02, r10, r11, r12, r20, r21, r22;
  logic signed [W-1:0] qw, qx, qy, qz;
  int errors = 0;
  int checks = 0;

  rotmat_to_quat #(.W(W), .ITER(ITER)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .r00(r00), .r01(r01), .r02(r02), .r10(r10), .r11(r11), .r12(r12),
    .r20(r20), .r21(r21), .r22(r22),
    .out_valid(out_valid), .out_ready(out_ready),
    .qw(qw), .qx(qx), .qy(qy), .qz(qz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp, input longint tol);
    longint d;
    checks++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic accept(input logic signed [W-1:0] a00, a01, a02, a10, a11, a12, a20, a21, a22);
    int n;
    r00 = a00; r01 = a01; r02 = a02;
    r10 = a10; r11 = a11; r12 = a12;
    r20 = a20; r21 = a21; r22 = a22;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("accept_timeout", 0, 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 2 + 4 * ITER, 0);
  endtask

  task automatic check_q(input string tag, input longint ew, ex, ey, ez, input longint tol);
    check({tag, "_qw"}, qw, ew, tol);
    check({tag, "_qx"}, qx, ex, tol);
    check({tag, "_qy"}, qy, ey, tol);
    check({tag, "_qz"}, qz, ez, tol);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0, 0);
    check({tag, "_ready_back"}, in_ready, 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int seen;
    logic signed [W-1:0] hw, hx, hy, hz;
    r00 = '0; r01 = '0; r02 = '0; r10 = '0; r11 = '0;
    r12 = '0; r20 = '0; r21 = '0; r22 = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0, 0);
    check("rst_in_ready", in_ready, 0, 0);
    check("rst_qw", qw, 0, 0);
    check("rst_qx", qx, 0, 0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", in_ready, 1, 0);
    @(posedge clk); #1;

    // Identity
    accept(P1, 0, 0, 0, P1, 0, 0, 0, P1);
    wait_out("ident");
    check_q("ident", 32'h40000000, 0, 0, 0, 0);
    release_out("ident");

    // 90 degrees about z: w/z tie goes to w
    accept(0, N1, 0, P1, 0, 0, 0, 0, P1);
    wait_out("rz90");
    check("rz90_qw", qw, 759250124, 0);
    check("rz90_qx", qx, 0, 0);
    check("rz90_qy", qy, 0, 0);
    check("rz90_qz", qz, 759250124, 2);
    release_out("rz90");

    // 180 degrees about x: h = 2^31 exactly
    accept(P1, 0, 0, 0, N1, 0, 0, 0, N1);
    wait_out("rx180");
    check_q("rx180", 0, 32'h40000000, 0, 0, 0);
    release_out("rx180");

    // -150 degrees about x: x branch then sign flip
    accept(P1, 0, 0, 0, C150, S150, 0, -S150, C150);
    wait_out("rxm150");
    check("rxm150_qw", qw, 277904834, 2);
    check("rxm150_qx", qx, -1037154959, 2);
    check("rxm150_qy", qy, 0, 0);
    check("rxm150_qz", qz, 0, 0);
    release_out("rxm150");

    // Backpressure for 20 cycles, then back-to-back transaction
    accept(P1, 0, 0, 0, N1, 0, 0, 0, N1);
    wait_out("bp");
    hw = qw; hx = qx; hy = qy; hz = qz;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || qw != hw || qx != hx || qy != hy || qz != hz) bad++;
    end
    check("bp_stable", bad, 0, 0);
    check_q("bp", 0, 32'h40000000, 0, 0, 0);
    release_out("bp");
    accept(0, N1, 0, P1, 0, 0, 0, 0, P1);
    wait_out("b2b");
    check("b2b_qw", qw, 759250124, 0);
    check("b2b_qz", qz, 759250124, 2);
    release_out("b2b");

    // Reset 50 cycles into a transaction
    accept(P1, 0, 0, 0, P1, 0, 0, 0, P1);
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", out_valid, 0, 0);
    check("midrst_in_ready", in_ready, 0, 0);
    check_q("midrst", 0, 0, 0, 0, 0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst_no_stale", seen, 0, 0);
    accept(P1, 0, 0, 0, C150, S150, 0, -S150, C150);
    wait_out("postrst");
    check("postrst_qw", qw, 277904834, 2);
    check("postrst_qx", qx, -1037154959, 2);
    check("postrst_qy", qy, 0, 0);
    check("postrst_qz", qz, 0, 0);
    release_out("postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
